// File: rtl/param_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : param_frame_generator
// Brief    : Snapshots a FRAME_LEN-word payload and streams SOF, payload and an
//            XOR checksum word, each carrying a parity bit, with backpressure.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_frame_generator #(
    parameter int          DATA_W      = 8,
    parameter int          FRAME_LEN   = 16,
    parameter bit          ODD_PARITY  = 1'b0,
    parameter logic [63:0] SOF_PATTERN = 64'h7E
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [FRAME_LEN*DATA_W-1:0] frame_data_in,
    output logic [DATA_W:0]             out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic                        busy,
    output logic                        done
);

    localparam int                  c_idx_w    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0]   c_sof      = SOF_PATTERN[DATA_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_buf [FRAME_LEN];
    logic [c_idx_w-1:0]  r_idx;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W:0]     r_out_data;
    logic                r_out_valid;
    logic                r_out_sof;
    logic                r_out_eof;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic [c_idx_w-1:0]  w_idx_inc;
    logic [DATA_W-1:0]   w_cur_word;
    logic [DATA_W-1:0]   w_next_word;
    logic [DATA_W-1:0]   w_acc_next;

    function automatic logic [DATA_W:0] with_parity(input logic [DATA_W-1:0] word);
        logic p;
        p = ODD_PARITY ? ~^word : ^word;
        return {p, word};
    endfunction

    assign w_xfer      = r_out_valid && out_ready;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_cur_word  = r_buf[r_idx];
    assign w_next_word = r_buf[w_idx_inc];
    assign w_acc_next  = r_acc ^ w_cur_word;

    // Each transition loads the word for the next state, so outputs stay
    // registered and hold steady while the downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < FRAME_LEN; i++) begin
                            r_buf[i] <= frame_data_in[i*DATA_W +: DATA_W];
                        end
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_out_data  <= with_parity(c_sof);
                        r_out_valid <= 1'b1;
                        r_out_sof   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_out_sof  <= 1'b0;
                        r_out_data <= with_parity(r_buf[0]);
                        r_state    <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_next;
                        if (r_idx == c_last_idx) begin
                            r_out_eof  <= 1'b1;
                            r_out_data <= with_parity(w_acc_next);
                            r_state    <= S_CHK;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_out_data <= with_parity(w_next_word);
                        end
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_out_eof   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_frame_generator
// Brief    : Scoreboard bench for param_frame_generator in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_frame_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    // dut0: defaults
    logic         reset_n0, start0, ready0;
    logic [127:0] data0;
    logic [8:0]   out_data0;
    logic         valid0, sof0, eof0, busy0, done0;
    // dut1: odd parity
    logic         reset_n1, start1, ready1;
    logic [127:0] data1;
    logic [8:0]   out_data1;
    logic         valid1, sof1, eof1, busy1, done1;
    // dut2: 4-bit words, 3-word frames
    logic         reset_n2, start2, ready2;
    logic [11:0]  data2;
    logic [4:0]   out_data2;
    logic         valid2, sof2, eof2, busy2, done2;

    param_frame_generator dut0 (
        .clk(clk), .reset_n(reset_n0), .start(start0), .frame_data_in(data0),
        .out_data(out_data0), .out_valid(valid0), .out_ready(ready0),
        .out_sof(sof0), .out_eof(eof0), .busy(busy0), .done(done0)
    );

    param_frame_generator #(.ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n1), .start(start1), .frame_data_in(data1),
        .out_data(out_data1), .out_valid(valid1), .out_ready(ready1),
        .out_sof(sof1), .out_eof(eof1), .busy(busy1), .done(done1)
    );

    param_frame_generator #(.DATA_W(4), .FRAME_LEN(3)) dut2 (
        .clk(clk), .reset_n(reset_n2), .start(start2), .frame_data_in(data2),
        .out_data(out_data2), .out_valid(valid2), .out_ready(ready2),
        .out_sof(sof2), .out_eof(eof2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // {sof, eof, parity<<dw | word}
    function automatic logic [10:0] ent(input bit sof, input bit eof, input logic [7:0] w,
                                        input int dw, input bit odd);
        logic       p;
        logic [8:0] d;
        p = (^w) ^ odd;
        d = {1'b0, w} | (9'(p) << dw);
        return {sof, eof, d};
    endfunction

    task automatic push(input int which, input logic [10:0] e);
        case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_frame(input int which, input logic [127:0] payload, input int dw,
                              input int len, input bit odd);
        logic [7:0] mask, w, acc;
        mask = 8'((1 << dw) - 1);
        acc  = '0;
        push(which, ent(1'b1, 1'b0, 8'h7E & mask, dw, odd));
        for (int i = 0; i < len; i++) begin
            w   = 8'(payload >> (i * dw)) & mask;
            acc = acc ^ w;
            push(which, ent(1'b0, 1'b0, w, dw, odd));
        end
        push(which, ent(1'b0, 1'b1, acc, dw, odd));
    endtask

    always @(negedge clk) begin
        if (valid0 && ready0) begin
            check("d0_sb_nonempty", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) check("d0_word", 32'({sof0, eof0, out_data0}), 32'(q0.pop_front()));
        end
        if (valid1 && ready1) begin
            check("d1_sb_nonempty", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) check("d1_word", 32'({sof1, eof1, out_data1}), 32'(q1.pop_front()));
        end
        if (valid2 && ready2) begin
            check("d2_sb_nonempty", 32'(q2.size() > 0), 1);
            if (q2.size() > 0) check("d2_word", 32'({sof2, eof2, 4'b0, out_data2}), 32'(q2.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic wait_done(input int which, input string tag);
        int n;
        n = 0;
        while (!get_done(which) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(get_done(which)), 1);
    endtask

    task automatic wait_word0(input logic [7:0] w, input string tag);
        int n;
        n = 0;
        while (!(valid0 && !sof0 && out_data0[7:0] == w) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(valid0 && out_data0[7:0] == w), 1);
    endtask

    logic [127:0] p0;
    int           nvalid;

    initial begin
        p0 = '0;
        for (int i = 0; i < 6; i++) p0[i*8 +: 8] = 8'(8'hAA + 8'h11 * i);
        for (int i = 0; i < 10; i++) p0[(6+i)*8 +: 8] = 8'(i + 1);

        reset_n0 = 0; reset_n1 = 0; reset_n2 = 0;
        start0 = 0; start1 = 0; start2 = 0;
        ready0 = 1; ready1 = 1; ready2 = 1;
        data0 = p0; data1 = p0; data2 = {4'h4, 4'h2, 4'h1};
        repeat (3) tick();
        check("rst_data", 32'(out_data0), 0);
        check("rst_valid", 32'(valid0), 0);
        check("rst_flags", 32'({sof0, eof0, busy0, done0}), 0);
        reset_n0 = 1; reset_n1 = 1; reset_n2 = 1;
        repeat (2) tick();
        check("idle_ready_no_effect", 32'({valid0, busy0}), 0);

        // Basic frame with ready tied high
        push_frame(0, p0, 8, 16, 1'b0);
        start0 = 1;
        tick();
        start0 = 0;
        check("d0_start_latency", 32'({valid0, busy0, sof0}), 32'b111);
        check("d0_sof_word", 32'(out_data0), 32'h07E);
        nvalid = 0;
        while (valid0 && nvalid < 40) begin
            nvalid++;
            tick();
        end
        check("d0_valid_len", nvalid, 18);
        check("d0_done_busy", 32'({done0, busy0}), 32'b10);
        tick();
        check("d0_done_pulse", 32'(done0), 0);
        check("d0_sb_drained", q0.size(), 0);

        // Backpressure on payload word 5
        push_frame(0, p0, 8, 16, 1'b0);
        start0 = 1;
        tick();
        start0 = 0;
        wait_word0(8'hFF, "d0_reach_ff");
        ready0 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d0_hold_valid", 32'(valid0), 1);
            check("d0_hold_data", 32'(out_data0), 32'h0FF);
        end
        ready0 = 1;
        wait_done(0, "d0_bp_done");
        check("d0_bp_sb_drained", q0.size(), 0);

        // Input change and second start mid-frame are ignored
        tick();
        push_frame(0, p0, 8, 16, 1'b0);
        start0 = 1;
        tick();
        start0 = 0;
        repeat (4) tick();
        data0  = '0;
        start0 = 1;
        tick();
        start0 = 0;
        wait_done(0, "d0_ign_done");
        repeat (3) tick();
        check("d0_no_queued_start", 32'({valid0, busy0}), 0);
        check("d0_ign_sb_drained", q0.size(), 0);
        data0 = p0;

        // Asynchronous reset during payload word 8
        push_frame(0, p0, 8, 16, 1'b0);
        start0 = 1;
        tick();
        start0 = 0;
        wait_word0(8'h03, "d0_reach_w8");
        #2;
        reset_n0 = 0;
        #1;
        check("d0_async_rst", 32'({valid0, busy0, out_data0}), 0);
        q0.delete();
        tick();
        reset_n0 = 1;
        tick();
        push_frame(0, p0, 8, 16, 1'b0);
        start0 = 1;
        tick();
        start0 = 0;
        wait_done(0, "d0_post_rst_done");
        check("d0_post_rst_sb", q0.size(), 0);

        // Odd parity
        push_frame(1, p0, 8, 16, 1'b1);
        start1 = 1;
        tick();
        start1 = 0;
        check("d1_sof_word", 32'(out_data1), 32'h17E);
        wait_done(1, "d1_done");
        check("d1_sb_drained", q1.size(), 0);

        // Narrow config, back-to-back frames
        push_frame(2, 128'(data2), 4, 3, 1'b0);
        push_frame(2, 128'(data2), 4, 3, 1'b0);
        start2 = 1;
        tick();
        start2 = 0;
        check("d2_sof_word", 32'(out_data2), 32'h1E);
        wait_done(2, "d2_done1");
        start2 = 1;
        tick();
        start2 = 0;
        check("d2_b2b_start", 32'({valid2, sof2, busy2}), 32'b111);
        wait_done(2, "d2_done2");
        check("d2_sb_drained", q2.size(), 0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
